cntr_ctrl: RTL and testbench

Control stage that sits directly upstream of the 4-bit loadable counter and drives its `pe`, `p` and `ce` inputs. It consumes the counter's `tc` output. It turns start/stop/load commands into a prescaled count-enable stream. At each terminal count it either reloads and keeps running (auto-reload) or reloads and halts (one-shot), and it reports status to the surrounding datapath.

---
 rtl/cntr_ctrl_pkg.sv | 30 +++
 rtl/cntr_ctrl_tick_gen.sv | 50 +++++
 rtl/cntr_ctrl.sv | 174 +++++++++++++++++
 tb/tb_cntr_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/cntr_ctrl_pkg.sv
// cntr_ctrl_pkg
// Shared definitions for the counter control stage:
//   - state_t and the ST_* constants: 3-bit FSM encoding
//     (IDLE=0, LOAD=1, RUN=2, PAUSE=3, DONE=4)
//   - TERM_CNT_W / TERM_CNT_MAX: width and ceiling of the optional
//     terminal-event counter
//   - term_sat_inc(): increment that sticks at TERM_CNT_MAX
// Optional feature macro used by the importing files: CNTR_CTRL_STATUS_EN.
package cntr_ctrl_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_LOAD  = 3'd1;
  localparam state_t ST_RUN   = 3'd2;
  localparam state_t ST_PAUSE = 3'd3;
  localparam state_t ST_DONE  = 3'd4;

  localparam int unsigned TERM_CNT_W = 8;
  localparam logic [TERM_CNT_W-1:0] TERM_CNT_MAX = '1;
  localparam logic [TERM_CNT_W-1:0] TERM_CNT_ONE = TERM_CNT_W'(1);

  // Saturating increment: once the ceiling is reached the value sticks.
  function automatic logic [TERM_CNT_W-1:0] term_sat_inc(
    input logic [TERM_CNT_W-1:0] v
  );
    return (v == TERM_CNT_MAX) ? v : (v + TERM_CNT_ONE);
  endfunction

endpackage

// File: rtl/cntr_ctrl_tick_gen.sv
// tick_gen
// Prescaler for the counter control stage. While run is high the internal
// count walks 0..DIV-1 and tick is high on the DIV-1 cycle, after which the
// count wraps to 0. While run is low the count holds, so a paused run resumes
// exactly where it stopped. clr forces the count back to 0.
// Ports:
//   clk   in  system clock
//   reset in  synchronous active-high reset
//   clr   in  clear the prescale count
//   run   in  advance the prescale count
//   tick  out one-cycle pulse every DIV running cycles
// Parameter DIV: prescale ratio, legal range 1..256.
module tick_gen #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic run,
  output logic tick
);

  // DIV=1 still needs a 1-bit register; it simply never leaves 0.
  localparam int unsigned   CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = run && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = tick ? '0 : (cnt_q + ONE);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cntr_ctrl.sv
// cntr_ctrl
// Control stage driving a 4-bit loadable counter (pe/p/ce) and consuming its
// terminal count. Start/stop/load commands become a prescaled count-enable
// stream; at every terminal event the counter is reloaded from p and the
// controller either keeps running (mode_reload=1) or halts in DONE.
// Ports:
//   clk         in  system clock
//   reset       in  synchronous active-high reset
//   start       in  run from IDLE / PAUSE / DONE
//   stop        in  pause while running
//   load        in  capture ld_val and preset the counter
//   mode_reload in  1 = auto-reload, 0 = one-shot (sampled at terminal)
//   ld_val      in  preset value
//   tc_in       in  counter terminal count ((q==4'hF) && ce)
//   pe          out counter parallel-load enable
//   p           out counter parallel-load value
//   ce          out counter count enable (prescaled tick)
//   busy        out high in RUN and PAUSE
//   done        out one-cycle pulse on each terminal event
//   term_cnt    out saturating terminal-event count
//                   (only when CNTR_CTRL_STATUS_EN is defined)
// Parameter DIV: prescale ratio, legal range 1..256.
module cntr_ctrl
  import cntr_ctrl_pkg::*;
#(
  parameter int unsigned DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       load,
  input  logic       mode_reload,
  input  logic [3:0] ld_val,
  input  logic       tc_in,
  output logic       pe,
  output logic [3:0] p,
  output logic       ce,
  output logic       busy,
  output logic       done
`ifdef CNTR_CTRL_STATUS_EN
  ,
  output logic [TERM_CNT_W-1:0] term_cnt
`endif
);

  state_t     state_q;
  state_t     state_d;
  logic [3:0] p_q;
  logic [3:0] p_d;

  logic in_run;
  logic presc_clr;
  logic tick;
  logic term_evt;
  logic load_acc;

  assign in_run = (state_q == ST_RUN);

  // Holding the prescaler at 0 outside RUN/PAUSE means every entry into RUN
  // from IDLE or DONE starts a fresh DIV-cycle period, while PAUSE (neither
  // cleared nor running) keeps the partial period.
  assign presc_clr = (state_q == ST_IDLE) || (state_q == ST_LOAD) ||
                     (state_q == ST_DONE);

  tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .clr   (presc_clr),
    .run   (in_run),
    .tick  (tick)
  );

  // tick is already gated by in_run, so ce is 0 outside RUN and a tc_in seen
  // without ce can never form a terminal event.
  assign ce       = tick;
  assign term_evt = tick && tc_in;
  assign load_acc = load && (state_q != ST_LOAD);

  assign pe   = (state_q == ST_LOAD) || term_evt;
  assign done = term_evt;
  assign busy = in_run || (state_q == ST_PAUSE);
  assign p    = p_q;

  always_comb begin
    p_d = p_q;
    if (load_acc) begin
      p_d = ld_val;
    end
  end

  // Priority in every state: load, then stop, then start. In RUN a one-shot
  // terminal event outranks stop, so the run ends in DONE rather than PAUSE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          state_d = ST_LOAD;
        end else if (!stop && start) begin
          state_d = ST_RUN;
        end
      end
      ST_LOAD: begin
        state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (load) begin
          state_d = ST_LOAD;
        end else if (term_evt && !mode_reload) begin
          state_d = ST_DONE;
        end else if (stop) begin
          state_d = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (load) begin
          state_d = ST_LOAD;
        end else if (!stop && start) begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (load) begin
          state_d = ST_LOAD;
        end else if (!stop && start) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
    end
  end

`ifdef CNTR_CTRL_STATUS_EN
  logic [TERM_CNT_W-1:0] term_cnt_q;
  logic [TERM_CNT_W-1:0] term_cnt_d;

  // An accepted load clears the count even if a terminal event happens in
  // the same cycle.
  always_comb begin
    term_cnt_d = term_cnt_q;
    if (load_acc) begin
      term_cnt_d = '0;
    end else if (term_evt) begin
      term_cnt_d = term_sat_inc(term_cnt_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      term_cnt_q <= '0;
    end else begin
      term_cnt_q <= term_cnt_d;
    end
  end

  assign term_cnt = term_cnt_q;
`endif

endmodule

// File: tb/tb_cntr_ctrl.sv
// tb_cntr_ctrl
// Directed bench for cntr_ctrl with DIV=4. A small behavioural 4-bit loadable
// counter closes the loop (pe overrides ce, tc = (q==F) && ce). Inputs change
// just after a falling edge and outputs are sampled on falling edges.
// Covers CNTR_CTRL_STATUS_EN when that macro is defined.
module tb_cntr_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       stop;
  logic       load;
  logic       mode_reload;
  logic [3:0] ld_val;
  logic       tc_in;
  logic       pe;
  logic [3:0] p;
  logic       ce;
  logic       busy;
  logic       done;
`ifdef CNTR_CTRL_STATUS_EN
  logic [7:0] term_cnt;
`endif

  logic [3:0] q_m;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  cntr_ctrl #(
    .DIV (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .load        (load),
    .mode_reload (mode_reload),
    .ld_val      (ld_val),
    .tc_in       (tc_in),
    .pe          (pe),
    .p           (p),
    .ce          (ce),
    .busy        (busy),
    .done        (done)
`ifdef CNTR_CTRL_STATUS_EN
    ,
    .term_cnt    (term_cnt)
`endif
  );

  // Downstream 4-bit loadable counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_m <= 4'h0;
    end else if (pe) begin
      q_m <= p;
    end else if (ce) begin
      q_m <= q_m + 4'h1;
    end
  end

  assign tc_in = (q_m == 4'hF) && ce;

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [15:0] snap();
    return {4'b0, pe, ce, busy, done, p, q_m};
  endfunction

  function automatic logic [15:0] ex(input logic pe_e, input logic ce_e,
                                     input logic busy_e, input logic done_e,
                                     input logic [3:0] p_e, input logic [3:0] q_e);
    return {4'b0, pe_e, ce_e, busy_e, done_e, p_e, q_e};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed {pe,ce,busy,done,p,q}=%04h expected=%04h",
                tag, obs, exp);
    $display("check %-12s observed=%04h expected=%04h", tag, obs, exp);
  endtask

  initial begin
    logic [3:0] qe;
    logic       ce_e;
    logic       dn_e;
    int         t;

    reset = 1'b1; start = 1'b0; stop = 1'b0; load = 1'b0;
    mode_reload = 1'b0; ld_val = 4'h0;
    tick(); tick();

    // start while reset is held must not move the FSM
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_start", snap(), ex(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0));
    end
    reset = 1'b0; start = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("idle", snap(), ex(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0));
      tick();
    end

    // single load of C: one pe pulse, then the counter holds C
    ld_val = 4'hC; load = 1'b1; tick(); load = 1'b0;
    chk("load_pe", snap(), ex(1'b1, 1'b0, 1'b0, 1'b0, 4'hC, 4'h0));
    tick();
    chk("load_q", snap(), ex(1'b0, 1'b0, 1'b0, 1'b0, 4'hC, 4'hC));

    // auto-reload from D: ce on every 4th RUN cycle, q cycles D,E,F
    ld_val = 4'hD; load = 1'b1; tick(); load = 1'b0;
    chk("load_d", snap(), ex(1'b1, 1'b0, 1'b0, 1'b0, 4'hD, 4'hC));
    tick();
    mode_reload = 1'b1; start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 24; k++) begin
      t    = k / 4;
      qe   = 4'hD + 4'(t % 3);
      ce_e = ((k % 4) == 3);
      dn_e = ce_e && ((k % 12) == 11);
      chk("reload", snap(), ex(dn_e, ce_e, 1'b1, dn_e, 4'hD, qe));
      tick();
    end
`ifdef CNTR_CTRL_STATUS_EN
    chk("term_cnt2", {8'b0, term_cnt}, 16'd2);
`endif

    // one-shot from E: terminal after 2 ticks, then DONE with ce quiet
    ld_val = 4'hE; load = 1'b1; mode_reload = 1'b0; tick(); load = 1'b0;
    chk("load_e", snap(), ex(1'b1, 1'b0, 1'b0, 1'b0, 4'hE, 4'hD));
    tick();
`ifdef CNTR_CTRL_STATUS_EN
    chk("term_clr", {8'b0, term_cnt}, 16'd0);
`endif
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      ce_e = (k == 3) || (k == 7);
      dn_e = (k == 7);
      qe   = (k < 4) ? 4'hE : 4'hF;
      chk("oneshot", snap(), ex(dn_e, ce_e, 1'b1, dn_e, 4'hE, qe));
      tick();
    end
    for (int i = 0; i < 20; i++) begin
      chk("done_hold", snap(), ex(1'b0, 1'b0, 1'b0, 1'b0, 4'hE, 4'hE));
      tick();
    end

    // pause at prescaler 2, hold 10 cycles, resume: ce on first RUN cycle
    mode_reload = 1'b1; start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      ce_e = (k == 3);
      qe   = (k < 4) ? 4'hE : 4'hF;
      chk("pre_pause", snap(), ex(1'b0, ce_e, 1'b1, 1'b0, 4'hE, qe));
      tick();
    end
    chk("pre_pause", snap(), ex(1'b0, 1'b0, 1'b1, 1'b0, 4'hE, 4'hF));
    stop = 1'b1; tick();
    for (int i = 0; i < 10; i++) begin
      chk("pause", snap(), ex(1'b0, 1'b0, 1'b1, 1'b0, 4'hE, 4'hF));
      tick();
    end
    stop = 1'b0; start = 1'b1; tick(); start = 1'b0;
    chk("resume", snap(), ex(1'b1, 1'b1, 1'b1, 1'b1, 4'hE, 4'hF));
    tick();

    // load of 3 landing on a terminal event: done pulses, load wins
    for (int j = 0; j < 7; j++) begin
      ce_e = (j == 3);
      qe   = (j < 4) ? 4'hE : 4'hF;
      chk("post_pause", snap(), ex(1'b0, ce_e, 1'b1, 1'b0, 4'hE, qe));
      tick();
    end
    chk("term_load", snap(), ex(1'b1, 1'b1, 1'b1, 1'b1, 4'hE, 4'hF));
    ld_val = 4'h3; load = 1'b1; tick(); load = 1'b0;
    chk("load_win", snap(), ex(1'b1, 1'b0, 1'b0, 1'b0, 4'h3, 4'hE));
`ifdef CNTR_CTRL_STATUS_EN
    chk("term_clr2", {8'b0, term_cnt}, 16'd0);
`endif
    tick();
    chk("load_win_q", snap(), ex(1'b0, 1'b0, 1'b0, 1'b0, 4'h3, 4'h3));

`ifdef CNTR_CTRL_STATUS_EN
    // preset F in auto-reload: every tick is a terminal event
    ld_val = 4'hF; load = 1'b1; tick(); load = 1'b0; tick();
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 1220; i++) begin
      tick();
    end
    chk("term_sat", {8'b0, term_cnt}, 16'd255);
`endif

    // reset while running returns everything to zero
    start = 1'b1; tick(); start = 1'b0;
    chk("run_busy", {15'b0, busy}, 16'd1);
    tick();
    reset = 1'b1; tick(); reset = 1'b0;
    chk("mid_reset", snap(), ex(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0));
`ifdef CNTR_CTRL_STATUS_EN
    chk("term_rst", {8'b0, term_cnt}, 16'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
